// File: rtl/jt49_noise_seq.sv
// jt49_noise_seq: queued {period, mask, hold} player driving the PSG noise path.
// Recirculating playback is built only when JT49_NOISE_SEQ_LOOP_EN is defined.
module jt49_noise_seq #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          wr,
   input  logic [4:0]    wr_period,
   input  logic [2:0]    wr_mask,
   input  logic [HW-1:0] wr_hold,
   input  logic          start,
   input  logic          stop,
   input  logic          loop,
   output logic          full,
   output logic          empty,
   output logic          busy,
   output logic [4:0]    period,
   output logic [2:0]    mask,
   output logic          done
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] { IDLE, LOAD, HOLD, FINISH } state_t;

   state_t        state_q;
   logic [4:0]    per_mem [DEPTH];
   logic [2:0]    msk_mem [DEPTH];
   logic [HW-1:0] hld_mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [HW-1:0] hold_q;
   logic [4:0]    period_q;
   logic [2:0]    mask_q;
   logic          done_q;
   logic          full_w, empty_w, pop_w, push_w, recirc_w;
   logic [4:0]    din_per;
   logic [2:0]    din_msk;
   logic [HW-1:0] din_hld;

`ifdef JT49_NOISE_SEQ_LOOP_EN
   // While looping the queue belongs to playback: each LOAD writes its head back to the tail.
   assign recirc_w = (state_q == LOAD) && loop;
   assign full_w   = (count_q == CW'(DEPTH)) || ((state_q != IDLE) && loop);
`else
   logic unused_loop;
   assign unused_loop = loop;
   assign recirc_w    = 1'b0;
   assign full_w      = (count_q == CW'(DEPTH));
`endif

   always_comb begin
      empty_w  = (count_q == '0);
      pop_w    = (state_q == LOAD);
      push_w   = (wr && !full_w && !stop) || recirc_w;
      din_per  = recirc_w ? per_mem[rd_ptr_q] : wr_period;
      din_msk  = recirc_w ? msk_mem[rd_ptr_q] : wr_mask;
      din_hld  = recirc_w ? hld_mem[rd_ptr_q] : wr_hold;
      wr_ptr_d = push_w ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_w  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push_w) - CW'(pop_w);
   end

   always_ff @(posedge clk) begin
      if (push_w) begin
         per_mem[wr_ptr_q] <= din_per;
         msk_mem[wr_ptr_q] <= din_msk;
         hld_mem[wr_ptr_q] <= din_hld;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
         period_q <= '0;
         mask_q   <= '0;
         done_q   <= 1'b0;
      end else if (stop) begin
         // period is left alone: the noise LFSR keeps running on the last value
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         mask_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         done_q   <= 1'b0;
         case (state_q)
            IDLE: if (start && !empty_w) state_q <= LOAD;
            LOAD: begin
               period_q <= per_mem[rd_ptr_q];
               mask_q   <= msk_mem[rd_ptr_q];
               hold_q   <= hld_mem[rd_ptr_q];
               state_q  <= HOLD;
            end
            HOLD: if (cen) begin
               if (hold_q != '0) begin
                  hold_q <= hold_q - HW'(1);
               end else if (!empty_w) begin
                  state_q <= LOAD;
               end else begin
                  state_q <= FINISH;
                  mask_q  <= '0;
                  done_q  <= 1'b1;
               end
            end
            FINISH: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign full   = full_w;
   assign empty  = empty_w;
   assign busy   = (state_q != IDLE);
   assign period = period_q;
   assign mask   = mask_q;
   assign done   = done_q;

endmodule

// File: tb/tb_jt49_noise_seq.sv
// Scoreboard bench for jt49_noise_seq: a timeline model predicts each entry's visible window and done.
module tb_jt49_noise_seq;
   localparam int DEPTH = 4;
   localparam int HW    = 8;
   localparam int LK    = 8;

   logic          clk = 1'b0;
   logic          rst, cen, wr, start, stop, loop;
   logic [4:0]    wr_period;
   logic [2:0]    wr_mask;
   logic [HW-1:0] wr_hold;
   logic          full, empty, busy, done;
   logic [4:0]    period;
   logic [2:0]    mask;

   jt49_noise_seq #(.DEPTH(DEPTH), .HW(HW)) dut (
      .clk(clk), .rst(rst), .cen(cen), .wr(wr), .wr_period(wr_period),
      .wr_mask(wr_mask), .wr_hold(wr_hold), .start(start), .stop(stop),
      .loop(loop), .full(full), .empty(empty), .busy(busy),
      .period(period), .mask(mask), .done(done)
   );

   always #5 clk = ~clk;

   // cyc is the index of the next rising edge as seen after the current one
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;
   int cen_div = 1;

   typedef struct { logic [4:0] p; logic [2:0] m; int h; } ent_t;
   typedef struct { bit is_done; logic [4:0] p; logic [2:0] m; int len; int t; } exp_t;
   ent_t mq[$];
   exp_t exq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic bit cen_at(input int e);
      return (cen_div <= 1) || ((e % cen_div) == 0);
   endfunction

   // Entry i becomes visible one edge after its LOAD, lasts hold+1 cen ticks, and is
   // shown through the following LOAD clk unless it is the last one.
   function automatic void plan(input ent_t es[$], input int s);
      int l, t0, e, ticks;
      exp_t x;
      l = s + 1;
      for (int i = 0; i < es.size(); i++) begin
         t0 = l + 1;
         e = t0 - 1;
         ticks = 0;
         while (ticks < es[i].h + 1) begin
            e++;
            if (cen_at(e)) ticks++;
         end
         x.is_done = 1'b0;
         x.p = es[i].p;
         x.m = es[i].m;
         x.t = t0;
         x.len = (i == es.size() - 1) ? (e - t0 + 1) : (e - t0 + 2);
         exq.push_back(x);
         l = e + 1;
      end
      x.is_done = 1'b1;
      x.p = '0;
      x.m = '0;
      x.len = 0;
      x.t = l;
      exq.push_back(x);
   endfunction

   task automatic clk1();
      cen = cen_at(cyc);
      @(posedge clk);
      #1;
      wr = 1'b0;
      start = 1'b0;
      stop = 1'b0;
   endtask

   task automatic push_ent(input int p, input int m, input int h);
      ent_t x;
      wr = 1'b1;
      wr_period = 5'(p);
      wr_mask = 3'(m);
      wr_hold = HW'(h);
      if (mq.size() < DEPTH) begin
         x.p = 5'(p);
         x.m = 3'(m);
         x.h = h;
         mq.push_back(x);
      end
      clk1();
   endtask

   task automatic do_start();
      start = 1'b1;
      if (mq.size() != 0) begin
         plan(mq, cyc);
         mq.delete();
      end
      clk1();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exq.size() != 0 || busy) && n < 2000) begin
         clk1();
         n++;
      end
      chk({name, "_pending"}, exq.size(), 0);
      chk({name, "_idle"}, busy, 0);
   endtask

   logic [4:0] sp;
   logic [2:0] sm;
   int sl, st;
   bit sact = 1'b0;

   task automatic close_seg();
      exp_t x;
      bit ok;
      ok = 1'b0;
      if (exq.size() != 0) ok = !exq[0].is_done;
      chk("seg_expected", ok, 1);
      if (ok) begin
         x = exq.pop_front();
         chk("seg_period", sp, x.p);
         chk("seg_mask", sm, x.m);
         chk("seg_len", sl, x.len);
         chk("seg_start", st, x.t);
      end
   endtask

   task automatic close_done();
      exp_t x;
      bit ok;
      ok = 1'b0;
      if (exq.size() != 0) ok = exq[0].is_done;
      chk("done_expected", ok, 1);
      if (ok) begin
         x = exq.pop_front();
         chk("done_cyc", cyc, x.t);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         sact = 1'b0;
      end else begin
         if (sact && period == sp && mask == sm) begin
            sl++;
         end else begin
            if (sact) close_seg();
            if (busy && mask != 3'd0) begin
               sact = 1'b1;
               sp = period;
               sm = mask;
               sl = 1;
               st = cyc;
            end else begin
               sact = 1'b0;
            end
         end
         if (done) close_done();
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      int s, xs, p, lastp, n;
      rst = 1'b1; cen = 1'b1; wr = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
      wr_period = '0; wr_mask = '0; wr_hold = '0;
      clk1();
      clk1();
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_period", period, 0);
      chk("rst_mask", mask, 0);
      chk("rst_done", done, 0);

      // three-entry sweep with cen always high
      cen_div = 1;
      push_ent(3, 1, 2);
      push_ent(7, 3, 0);
      push_ent(31, 7, 1);
      do_start();
      drain("basic");
      chk("basic_period_kept", period, 31);
      chk("basic_mask_clr", mask, 0);

      // overfill: fifth write is dropped
      for (int k = 0; k < DEPTH + 1; k++) begin
         push_ent(k + 1, (k % 7) + 1, k % 3);
         chk("fill_full", full, (mq.size() == DEPTH) ? 1 : 0);
         chk("fill_empty", empty, 0);
      end
      cen_div = 3;
      do_start();
      drain("fill");
      chk("fill_empty_after", empty, 1);

      // sparse cen, busy must hold through the entry
      cen_div = 4;
      push_ent(17, 4, 1);
      do_start();
      for (int k = 0; k < 6; k++) begin
         chk("sparse_busy", busy, 1);
         clk1();
      end
      drain("sparse");

      // stop mid-HOLD with a write in the same clk
      cen_div = 1;
      push_ent(10, 5, 6);
      push_ent(20, 2, 1);
      s = cyc;
      start = 1'b1;
      mq.delete();
      clk1();
      while (cyc < s + 4) clk1();
      xs = cyc;
      begin
         exp_t x;
         x.is_done = 1'b0; x.p = 5'd10; x.m = 3'd5; x.t = s + 2; x.len = xs - (s + 2) + 1;
         exq.push_back(x);
      end
      stop = 1'b1;
      wr = 1'b1; wr_period = 5'd1; wr_mask = 3'd1; wr_hold = '0;
      clk1();
      chk("stop_busy", busy, 0);
      chk("stop_mask", mask, 0);
      chk("stop_empty", empty, 1);
      chk("stop_full", full, 0);
      chk("stop_done", done, 0);
      chk("stop_period", period, 10);
      repeat (3) clk1();
      chk("stop_pending", exq.size(), 0);

      // start on empty queue, then start together with the first write
      start = 1'b1;
      clk1();
      chk("estart_busy", busy, 0);
      repeat (3) clk1();
      start = 1'b1;
      push_ent(12, 3, 1);
      chk("wstart_busy", busy, 0);
      chk("wstart_empty", empty, 0);
      do_start();
      drain("wstart");

      // loop mode: two hold-0 entries alternate, then loop is dropped
      cen_div = 1;
      push_ent(5, 1, 0);
      push_ent(9, 6, 0);
      loop = 1'b1;
      s = cyc;
`ifdef JT49_NOISE_SEQ_LOOP_EN
      begin
         ent_t es[$];
         for (int k = 0; k < LK + 2; k++) es.push_back(mq[k % 2]);
         start = 1'b1;
         plan(es, s);
         mq.delete();
         clk1();
         wr = 1'b1; wr_period = 5'd30; wr_mask = 3'd7; wr_hold = '0;
         clk1();
         while (cyc < s + 1 + 2 * LK) begin
            chk("loop_full", full, 1);
            chk("loop_empty", empty, 0);
            clk1();
         end
         loop = 1'b0;
         drain("loop");
      end
`else
      do_start();
      drain("loop_ignored");
      loop = 1'b0;
`endif
      chk("loop_end_empty", empty, 1);

      // randomized sweeps
      for (int r = 0; r < 8; r++) begin
         cen_div = $urandom_range(1, 3);
         n = $urandom_range(1, DEPTH + 1);
         lastp = -1;
         for (int k = 0; k < n; k++) begin
            p = $urandom_range(0, 31);
            if (p == lastp) p = (p + 1) % 32;
            lastp = p;
            push_ent(p, $urandom_range(1, 7), $urandom_range(0, 3));
         end
         do_start();
         start = 1'b1;
         clk1();
         drain("rand");
         chk("rand_empty", empty, 1);
         repeat ($urandom_range(0, 3)) clk1();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
